// File: rtl/bf_pkg.sv
// Shared definitions for the Bellman-Ford sequencing logic.
// Holds the run-state encoding and the default sizing constants used by
// bf_sequence_ctrl and its testbench.
package bf_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } bf_seq_state_t;

    localparam int BF_STEPS    = 3;
    localparam int BF_PHASES   = 2;
    localparam int BF_MAX_ITER = 1500;
    localparam int BF_ITER_W   = 11;

endpackage

// File: rtl/bf_wrap_counter.sv
// Wrapping up-counter used for the step and phase positions of a sweep.
// Counts 0..LIMIT-1 and wraps to 0; a clear has priority over counting.
// Ports:
//   clk     - rising-edge clock
//   rst_n   - asynchronous active-low reset
//   clr     - synchronous clear to 0 (priority over en)
//   en      - advance by one, wrapping after LIMIT-1
//   count   - current value
//   at_last - count equals LIMIT-1
module bf_wrap_counter #(
    parameter int WIDTH = 2,
    parameter int LIMIT = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             en,
    output logic [WIDTH-1:0] count,
    output logic             at_last
);

    localparam logic [WIDTH-1:0] LAST = WIDTH'(LIMIT - 1);

    assign at_last = (count == LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en) begin
            count <= at_last ? '0 : count + WIDTH'(1);
        end
    end

endmodule

// File: rtl/bf_sequence_ctrl.sv
// Step/phase/iteration sequencer for the Bellman-Ford relaxation array.
// Runs an IDLE -> RUN -> DONE state machine, walks step/phase positions
// with a one-cycle bubble after each sweep, counts relaxation iterations
// and stops on the iteration limit or on convergence.
// Ports:
//   clk, rst_global_n          - clock, asynchronous active-low reset
//   start                      - begin/restart a run (IDLE or DONE only)
//   read_enable_global         - read-back request, clears step/phase locally
//   stall                      - freeze step/phase for this cycle
//   iteration_done, no_update  - end-of-iteration strobe and its "no change" flag
//   step_counter, phase_counter- current sweep position
//   iteration_counter          - completed iterations (saturates at MAX_ITER)
//   pre_rollover_phase_counter - last step of last phase (combinational)
//   rollover_phase_counter     - registered copy of the above (bubble cycle)
//   busy, finish, done_pulse   - RUN level, DONE level, DONE entry strobe
//   converged                  - run ended on no_update
module bf_sequence_ctrl
    import bf_pkg::*;
#(
    parameter  int STEPS    = BF_STEPS,
    parameter  int PHASES   = BF_PHASES,
    parameter  int MAX_ITER = BF_MAX_ITER,
    parameter  int ITER_W   = BF_ITER_W,
    localparam int STEP_W   = $clog2(STEPS),
    localparam int PHASE_W  = (PHASES > 2) ? $clog2(PHASES) : 1
) (
    input  logic               clk,
    input  logic               rst_global_n,
    input  logic               start,
    input  logic               read_enable_global,
    input  logic               stall,
    input  logic               iteration_done,
    input  logic               no_update,
    output logic [STEP_W-1:0]  step_counter,
    output logic [PHASE_W-1:0] phase_counter,
    output logic [ITER_W-1:0]  iteration_counter,
    output logic               pre_rollover_phase_counter,
    output logic               rollover_phase_counter,
    output logic               busy,
    output logic               finish,
    output logic               done_pulse,
    output logic               converged
);

    localparam logic [ITER_W-1:0] ITER_LAST = ITER_W'(MAX_ITER - 1);
    localparam logic [ITER_W-1:0] ITER_FULL = ITER_W'(MAX_ITER);

    bf_seq_state_t state;
    bf_seq_state_t state_next;

    logic read_enable_global_q;
    logic lclr;
    logic run;
    logic enter_run;
    logic step_last;
    logic phase_last;
    logic step_clr;
    logic phase_clr;
    logic phase_en;
    logic done_cond;

    assign run  = (state == RUN);
    // Read-back holds the counters clear for the request cycle and the next.
    assign lclr = read_enable_global | read_enable_global_q;

    assign pre_rollover_phase_counter = run & step_last & phase_last & ~stall;

    // Outside RUN the position is pinned at 0, which also covers the clear
    // required when a run (re)starts.
    assign step_clr  = ~run | lclr | rollover_phase_counter;
    assign phase_clr = ~run | lclr | rollover_phase_counter | pre_rollover_phase_counter;
    assign phase_en  = step_last & ~stall;

    assign done_cond = run & iteration_done & (no_update | (iteration_counter == ITER_LAST));
    assign enter_run = ~run & (state_next == RUN);

    assign busy   = run;
    assign finish = (state == DONE);

    bf_wrap_counter #(
        .WIDTH (STEP_W),
        .LIMIT (STEPS)
    ) u_step (
        .clk     (clk),
        .rst_n   (rst_global_n),
        .clr     (step_clr),
        .en      (~stall),
        .count   (step_counter),
        .at_last (step_last)
    );

    bf_wrap_counter #(
        .WIDTH (PHASE_W),
        .LIMIT (PHASES)
    ) u_phase (
        .clk     (clk),
        .rst_n   (rst_global_n),
        .clr     (phase_clr),
        .en      (phase_en),
        .count   (phase_counter),
        .at_last (phase_last)
    );

    // Run state machine: start is only honoured outside RUN.
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: if (start)     state_next = RUN;
            RUN:  if (done_cond) state_next = DONE;
            DONE: if (start)     state_next = RUN;
            default:             state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_global_n) begin
        if (!rst_global_n) begin
            state                  <= IDLE;
            read_enable_global_q   <= 1'b0;
            rollover_phase_counter <= 1'b0;
            done_pulse             <= 1'b0;
        end else begin
            state                  <= state_next;
            read_enable_global_q   <= read_enable_global;
            rollover_phase_counter <= lclr ? 1'b0 : pre_rollover_phase_counter;
            done_pulse             <= run & (state_next == DONE);
        end
    end

    // Iteration count and convergence flag; stall and read-back do not apply.
    always_ff @(posedge clk or negedge rst_global_n) begin
        if (!rst_global_n) begin
            iteration_counter <= '0;
            converged         <= 1'b0;
        end else if (enter_run) begin
            iteration_counter <= '0;
            converged         <= 1'b0;
        end else begin
            if (run && iteration_done && (iteration_counter != ITER_FULL)) begin
                iteration_counter <= iteration_counter + ITER_W'(1);
            end
            if (done_cond && no_update) begin
                converged <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_bf_sequence_ctrl.sv
// Directed testbench for bf_sequence_ctrl: one default instance and one
// with a limit of 4 iterations, driven from a shared set of inputs.
module tb_bf_sequence_ctrl;

    logic        clk = 1'b0;
    logic        rst_global_n;
    logic        start;
    logic        read_enable_global;
    logic        stall;
    logic        iteration_done;
    logic        no_update;

    logic [1:0]  step_counter;
    logic [0:0]  phase_counter;
    logic [10:0] iteration_counter;
    logic        pre_rollover_phase_counter;
    logic        rollover_phase_counter;
    logic        busy;
    logic        finish;
    logic        done_pulse;
    logic        converged;

    logic [1:0]  step_4;
    logic [0:0]  phase_4;
    logic [10:0] count_4;
    logic        pre_4;
    logic        roll_4;
    logic        busy_4;
    logic        finish_4;
    logic        done_pulse_4;
    logic        converged_4;

    int total = 0;
    int bad   = 0;

    int sweep_step [1:14] = '{0, 1, 2, 0, 1, 2, 0, 0, 1, 2, 0, 1, 2, 0};

    always #5 clk = ~clk;

    bf_sequence_ctrl dut (
        .clk                        (clk),
        .rst_global_n               (rst_global_n),
        .start                      (start),
        .read_enable_global         (read_enable_global),
        .stall                      (stall),
        .iteration_done             (iteration_done),
        .no_update                  (no_update),
        .step_counter               (step_counter),
        .phase_counter              (phase_counter),
        .iteration_counter          (iteration_counter),
        .pre_rollover_phase_counter (pre_rollover_phase_counter),
        .rollover_phase_counter     (rollover_phase_counter),
        .busy                       (busy),
        .finish                     (finish),
        .done_pulse                 (done_pulse),
        .converged                  (converged)
    );

    bf_sequence_ctrl #(.MAX_ITER(4)) dut4 (
        .clk                        (clk),
        .rst_global_n               (rst_global_n),
        .start                      (start),
        .read_enable_global         (read_enable_global),
        .stall                      (stall),
        .iteration_done             (iteration_done),
        .no_update                  (no_update),
        .step_counter               (step_4),
        .phase_counter              (phase_4),
        .iteration_counter          (count_4),
        .pre_rollover_phase_counter (pre_4),
        .rollover_phase_counter     (roll_4),
        .busy                       (busy_4),
        .finish                     (finish_4),
        .done_pulse                 (done_pulse_4),
        .converged                  (converged_4)
    );

    task automatic check_output(input string tag, input logic [31:0] observed,
                                input logic [31:0] expected);
        total++;
        assert (observed === expected) else begin
            bad++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    // Advance one clock and settle just after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_global_n = 1'b0;
        #3;
        rst_global_n = 1'b1;
        tick();
    endtask

    task automatic start_run();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic pulse_done(input logic nu);
        iteration_done = 1'b1;
        no_update      = nu;
        tick();
        iteration_done = 1'b0;
        no_update      = 1'b0;
    endtask

    initial begin
        rst_global_n       = 1'b0;
        start              = 1'b0;
        read_enable_global = 1'b0;
        stall              = 1'b0;
        iteration_done     = 1'b0;
        no_update          = 1'b0;
        #12;
        check_output("rst_step",  step_counter, 0);
        check_output("rst_count", iteration_counter, 0);
        check_output("rst_busy",  busy, 0);
        check_output("rst_finish", finish, 0);
        rst_global_n = 1'b1;
        tick();

        // Reset in the middle of a run: step=2, phase=1, count=37.
        $display("[TB] reset mid-run");
        start_run();
        iteration_done = 1'b1;
        for (int i = 0; i < 37; i++) tick();
        iteration_done = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        check_output("mid_step",  step_counter, 2);
        check_output("mid_phase", phase_counter, 1);
        check_output("mid_count", iteration_counter, 37);
        check_output("mid_busy",  busy, 1);
        rst_global_n = 1'b0;
        #1;
        check_output("arst_step",  step_counter, 0);
        check_output("arst_phase", phase_counter, 0);
        check_output("arst_count", iteration_counter, 0);
        check_output("arst_pre",   pre_rollover_phase_counter, 0);
        check_output("arst_roll",  rollover_phase_counter, 0);
        check_output("arst_busy",  busy, 0);
        check_output("arst_finish", finish, 0);
        check_output("arst_dpulse", done_pulse, 0);
        check_output("arst_conv",  converged, 0);
        rst_global_n = 1'b1;
        tick();

        // Free-running sweep pattern.
        $display("[TB] sweep");
        do_reset();
        start_run();
        check_output("sweep_busy", busy, 1);
        for (int k = 1; k <= 14; k++) begin
            check_output("sweep_step", step_counter, sweep_step[k]);
            check_output("sweep_pre",  pre_rollover_phase_counter, (k == 6 || k == 13) ? 1 : 0);
            check_output("sweep_roll", rollover_phase_counter, (k == 7 || k == 14) ? 1 : 0);
            tick();
        end

        // Iteration limit of 4 on the second instance.
        $display("[TB] limit");
        do_reset();
        start_run();
        for (int i = 1; i <= 3; i++) begin
            pulse_done(1'b0);
            check_output("lim_count", count_4, i);
            check_output("lim_finish_early", finish_4, 0);
        end
        pulse_done(1'b0);
        check_output("lim_count4", count_4, 4);
        check_output("lim_finish", finish_4, 1);
        check_output("lim_dpulse", done_pulse_4, 1);
        check_output("lim_conv",   converged_4, 0);
        check_output("lim_busy",   busy_4, 0);
        tick();
        check_output("lim_dpulse_off", done_pulse_4, 0);
        check_output("lim_finish_lvl", finish_4, 1);
        pulse_done(1'b0);
        check_output("lim_sat", count_4, 4);

        // Convergence on the third iteration.
        $display("[TB] convergence");
        do_reset();
        start_run();
        pulse_done(1'b0);
        pulse_done(1'b0);
        check_output("conv_pre", converged, 0);
        pulse_done(1'b1);
        check_output("conv_count",  iteration_counter, 3);
        check_output("conv_flag",   converged, 1);
        check_output("conv_finish", finish, 1);
        check_output("conv_dpulse", done_pulse, 1);
        pulse_done(1'b0);
        check_output("conv_ignored", iteration_counter, 3);
        start_run();
        check_output("restart_count", iteration_counter, 0);
        check_output("restart_conv",  converged, 0);
        check_output("restart_busy",  busy, 1);
        check_output("restart_finish", finish, 0);

        // Read-back clear at step=1, phase=1.
        $display("[TB] read-back");
        do_reset();
        start_run();
        iteration_done = 1'b1;
        tick();
        tick();
        iteration_done = 1'b0;
        tick();
        tick();
        check_output("rb_step0",  step_counter, 1);
        check_output("rb_phase0", phase_counter, 1);
        check_output("rb_count0", iteration_counter, 2);
        read_enable_global = 1'b1;
        tick();
        read_enable_global = 1'b0;
        check_output("rb_step1",  step_counter, 0);
        check_output("rb_phase1", phase_counter, 0);
        check_output("rb_roll1",  rollover_phase_counter, 0);
        tick();
        check_output("rb_step2",  step_counter, 0);
        check_output("rb_phase2", phase_counter, 0);
        check_output("rb_roll2",  rollover_phase_counter, 0);
        tick();
        check_output("rb_step3",  step_counter, 1);
        check_output("rb_roll3",  rollover_phase_counter, 0);
        check_output("rb_count3", iteration_counter, 2);

        // Stall for 3 cycles at step=2, phase=1.
        $display("[TB] stall");
        do_reset();
        start_run();
        for (int i = 0; i < 5; i++) tick();
        check_output("st_pre_free", pre_rollover_phase_counter, 1);
        stall = 1'b1;
        #1;
        check_output("st_pre0",   pre_rollover_phase_counter, 0);
        check_output("st_step0",  step_counter, 2);
        check_output("st_phase0", phase_counter, 1);
        for (int i = 0; i < 2; i++) begin
            tick();
            check_output("st_step",  step_counter, 2);
            check_output("st_phase", phase_counter, 1);
            check_output("st_pre",   pre_rollover_phase_counter, 0);
            check_output("st_roll",  rollover_phase_counter, 0);
        end
        tick();
        stall = 1'b0;
        #1;
        check_output("st_pre_resume", pre_rollover_phase_counter, 1);
        check_output("st_step_hold",  step_counter, 2);
        tick();
        check_output("st_roll_after", rollover_phase_counter, 1);
        check_output("st_step_after", step_counter, 0);
        check_output("st_phase_after", phase_counter, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/bf_sequence_ctrl.md
# bf_sequence_ctrl

Parametrised step/phase/iteration sequencer for the Bellman-Ford relaxation array. It generalises the fixed 3-step × 2-phase × 1500-iteration counter block to configurable step count, phase count and iteration limit. It adds an explicit run state machine, stall, a start/restart handshake and early termination on convergence. It sits between the top-level control (start, read-back enable) and the 16×16 PE array, which consumes `step_counter`, `phase_counter` and the rollover strobes.

## Interface

Parameters:
- `STEPS`, default 3: steps per phase, must be ≥2.
- `PHASES`, default 2: phases per sweep, must be ≥2.
- `MAX_ITER`, default 1500: iteration limit.
- `ITER_W`, default 11: iteration counter width; must satisfy 2^ITER_W > MAX_ITER.

Ports:
- `clk` — in, 1: single clock, all logic on the rising edge.
- `rst_global_n` — in, 1: reset, asynchronous, active-low.
- `start` — in, 1: begin (or restart) a run; sampled in IDLE or DONE.
- `read_enable_global` — in, 1: read-back request; locally clears the step/phase counters.
- `stall` — in, 1: freezes the step/phase counters for this cycle.
- `iteration_done` — in, 1: single-cycle strobe from the array marking the end of one relaxation iteration.
- `no_update` — in, 1: qualifies `iteration_done`; no distance changed in that iteration.
- `step_counter` — out, `$clog2(STEPS)`: current step.
- `phase_counter` — out, `max(1,$clog2(PHASES))`: current phase.
- `iteration_counter` — out, `ITER_W`: completed iterations.
- `pre_rollover_phase_counter` — out, 1: combinational; last step of last phase.
- `rollover_phase_counter` — out, 1: registered `pre_rollover_phase_counter`.
- `busy` — out, 1: state is RUN.
- `finish` — out, 1: state is DONE (level).
- `done_pulse` — out, 1: one cycle, on entry to DONE.
- `converged` — out, 1: the run ended on `no_update`, not on the limit.

## Operation

- States:
  - IDLE (reset) —`start`→ RUN.
  - RUN —limit or convergence→ DONE.
  - DONE —`start`→ RUN.
  - No other transitions.
- Entering RUN clears `iteration_counter`, `converged`, step, phase and rollover.
- Local clear `lclr` = `read_enable_global | read_enable_global_q`, where `read_enable_global_q` is a 1-cycle delayed copy.
  - `lclr` forces step, phase and rollover to 0.
  - It does not touch state or `iteration_counter`.
- Step counter, in RUN only:
  - Cleared if `lclr`, `rollover_phase_counter`, or step==STEPS-1 (with `!stall`).
  - Otherwise +1 unless `stall`.
  - Held at 0 outside RUN.
- Phase counter:
  - Cleared on `lclr`, on `rollover_phase_counter`, or on `pre_rollover_phase_counter`.
  - Otherwise +1 when step==STEPS-1 and `!stall`.
- `pre_rollover_phase_counter` = RUN & step==STEPS-1 & phase==PHASES-1 & `!stall`.
- `rollover_phase_counter` is cleared by `lclr`; otherwise it follows `pre_rollover_phase_counter` delayed one cycle.
- The rollover cycle is a bubble (step and phase held at 0). The sweep period is therefore STEPS×PHASES+1 cycles; it is 7 at the defaults.
- Iteration counting:
  - In RUN, `iteration_done` increments `iteration_counter`, saturating at MAX_ITER.
  - `iteration_done` is ignored in IDLE and DONE.
- RUN→DONE happens on either of:
  - `iteration_done & no_update`, which also sets `converged`=1;
  - `iteration_done` with count==MAX_ITER-1, which takes the count to MAX_ITER.
- If both conditions hold at once: transition to DONE, `converged`=1, count=MAX_ITER.
- `start` while in RUN is ignored.
- `stall` does not affect the iteration logic.

## Timing

- Reset values: all outputs 0; state IDLE; `read_enable_global_q`=0.
- Asynchronous assertion. Deassertion is synchronised upstream and is not this block's concern.
- `start` in cycle t: `busy`=1 at t+1, step=0 at t+1, step=1 at t+2.
- `iteration_done` at t: the new count is visible at t+1.
- Termination at t: `finish` and `done_pulse` are both 1 at t+1; `done_pulse` is 0 at t+2.
- `read_enable_global` high for one cycle at t: step/phase are 0 at t+1 and t+2, and resume counting at t+3.
- `stall` at t: step/phase at t+1 equal their values at t.

## Structure

- Shared package `bf_pkg` holds:
  - state enum `bf_seq_state_t` {IDLE, RUN, DONE};
  - default constants `BF_STEPS`, `BF_PHASES`, `BF_MAX_ITER`, `BF_ITER_W`.
- One sub-module, `bf_wrap_counter`: parametrised width/limit counter with `clr`, `en` and a `at_last` output. It is instantiated twice, for step and phase.
- The iteration counter and FSM stay inline.

## Test plan

All scenarios use defaults unless stated.

- **Reset mid-run:** assert `rst_global_n`=0 with step=2, phase=1, count=37 → all outputs 0 immediately (asynchronous), state IDLE.
- **Sweep pattern:** `start`, then free-run 14 cycles → step sequence 0,1,2,0,1,2,0,0,1,2,0,1,2,0; `pre_rollover_phase_counter` high on the 6th and 13th cycles; `rollover_phase_counter` one cycle later.
- **Limit:** MAX_ITER=4, four `iteration_done` pulses with `no_update`=0 → count 4, `finish`=1, one-cycle `done_pulse`, `converged`=0; a fifth pulse leaves count at 4.
- **Convergence:** third `iteration_done` has `no_update`=1 → count 3, `converged`=1, `finish`=1; `iteration_done` in DONE ignored; then `start` → count 0, `converged`=0, `busy`=1.
- **Read-back:** `read_enable_global` for 1 cycle at step=1, phase=1 → step/phase 0 for 2 cycles, no rollover strobe, count unchanged.
- **Stall:** `stall` for 3 cycles at step=2, phase=1 → counters frozen, `pre_rollover_phase_counter`=0 while stalled; rollover fires on the first unstalled cycle.
